// File: rtl/key_mode_ctrl.sv
// Push-button front end: synchronizer, debounce FSM, short/long press decode
// driving the LED mode register, plus a free-running pattern tick.
module key_mode_ctrl #(
  parameter int DEB_CYCLES  = 20,
  parameter int LONG_CYCLES = 200,
  parameter int TICK_DIV    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [1:0] mode,
  output logic       mode_chg,
  output logic       long_press,
  output logic       key_state,
  output logic       tick
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t state, state_n;

  logic          sync1, sync2;
  logic          key_s;
  logic [DW-1:0] deb, deb_n;
  logic [HW-1:0] hold, hold_n;
  logic          long_seen, long_seen_n;
  logic [1:0]    mode_n;
  logic          mode_chg_n;
  logic          long_press_n;
  logic [TW-1:0] tcnt;

  assign key_s     = ~sync2;
  assign key_state = (state == PRESSED) || (state == RELEASE_WAIT);
  assign tick      = (tcnt == TICK_LAST);

  always_comb begin
    state_n      = state;
    deb_n        = deb;
    hold_n       = hold;
    long_seen_n  = long_seen;
    mode_n       = mode;
    mode_chg_n   = 1'b0;
    long_press_n = 1'b0;

    // Hold timing runs first so a release finishing in the same
    // cycle as the long-press threshold still sees it.
    if (key_state && (hold != HOLD_MAX)) begin
      hold_n = hold + HW'(1);
      if ((hold == HOLD_LAST) && !long_seen) begin
        long_press_n = 1'b1;
        long_seen_n  = 1'b1;
        mode_n       = 2'd0;
        mode_chg_n   = (mode != 2'd0);
      end
    end

    unique case (state)
      RELEASED: begin
        if (key_s) begin
          state_n = PRESS_WAIT;
          deb_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_n = RELEASED;
        end else if (deb == DEB_LAST) begin
          state_n     = PRESSED;
          hold_n      = '0;
          long_seen_n = 1'b0;
        end else begin
          deb_n = deb + DW'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_n = RELEASE_WAIT;
          deb_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_n = PRESSED;
        end else if (deb == DEB_LAST) begin
          state_n = RELEASED;
          if (!long_seen_n) begin
            mode_n     = mode + 2'd1;
            mode_chg_n = 1'b1;
          end
        end else begin
          deb_n = deb + DW'(1);
        end
      end
      default: state_n = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= RELEASED;
      deb        <= '0;
      hold       <= '0;
      long_seen  <= 1'b0;
      mode       <= 2'd0;
      mode_chg   <= 1'b0;
      long_press <= 1'b0;
      tcnt       <= '0;
    end else begin
      sync1      <= key_in;
      sync2      <= sync1;
      state      <= state_n;
      deb        <= deb_n;
      hold       <= hold_n;
      long_seen  <= long_seen_n;
      mode       <= mode_n;
      mode_chg   <= mode_chg_n;
      long_press <= long_press_n;
      tcnt       <= (tcnt == TICK_LAST) ? '0 : tcnt + TW'(1);
    end
  end

endmodule
